delay_arb: RTL

DELAY_ARB -- requirements
Module: delay_arb

---
 rtl/delay_arb_if.sv | 32 +++
 rtl/delay_arb.sv | 76 +++++++
 2 files changed

// File: rtl/delay_arb_if.sv
// Handshake and response bundle for delay_arb.
// The slave modport is the arbiter's view and the master modport is the requesters' view.
interface delay_arb_if #(
    parameter int unsigned DATA_W = 8
);
    logic              i_enable;
    logic              i_req0_valid;
    logic [DATA_W-1:0] iv_req0_data;
    logic              o_req0_ready;
    logic              i_req1_valid;
    logic [DATA_W-1:0] iv_req1_data;
    logic              o_req1_ready;
    logic              o_rsp0_valid;
    logic [DATA_W-1:0] ov_rsp0_data;
    logic              o_rsp1_valid;
    logic [DATA_W-1:0] ov_rsp1_data;
    logic [3:0]        ov_inflight;
    logic [15:0]       ov_gnt0_cnt;
    logic [15:0]       ov_gnt1_cnt;

    modport slave (
        input  i_enable, i_req0_valid, iv_req0_data, i_req1_valid, iv_req1_data,
        output o_req0_ready, o_req1_ready, o_rsp0_valid, ov_rsp0_data,
        output o_rsp1_valid, ov_rsp1_data, ov_inflight, ov_gnt0_cnt, ov_gnt1_cnt
    );

    modport master (
        output i_enable, i_req0_valid, iv_req0_data, i_req1_valid, iv_req1_data,
        input  o_req0_ready, o_req1_ready, o_rsp0_valid, ov_rsp0_data,
        input  o_rsp1_valid, ov_rsp1_data, ov_inflight, ov_gnt0_cnt, ov_gnt1_cnt
    );
endinterface

// File: rtl/delay_arb.sv
// Two-requester round-robin arbiter feeding one shared, never-stalling delay pipeline.
// Each pipeline word carries a tag that steers it back to its requester's response port.
module delay_arb #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    delay_arb_if.slave   bus
);
    logic              ptr_q;
    logic              acc0, acc1, acc;
    logic [DEPTH-1:0]  vld_q;
    logic              tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [15:0]       gnt0_cnt_q, gnt1_cnt_q;
    logic [3:0]        inflight;

    // The pointer only breaks ties; a lone valid always wins.
    always_comb begin
        bus.o_req0_ready = bus.i_enable & bus.i_req0_valid & (~bus.i_req1_valid | ~ptr_q);
        bus.o_req1_ready = bus.i_enable & bus.i_req1_valid & (~bus.i_req0_valid | ptr_q);
    end

    assign acc0 = bus.o_req0_ready & bus.i_req0_valid;
    assign acc1 = bus.o_req1_ready & bus.i_req1_valid;
    assign acc  = acc0 | acc1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= 1'b0;
            vld_q      <= '0;
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            if (acc) begin
                ptr_q <= acc0;
            end
            if (acc0 && gnt0_cnt_q != 16'hFFFF) begin
                gnt0_cnt_q <= gnt0_cnt_q + 16'd1;
            end
            if (acc1 && gnt1_cnt_q != 16'hFFFF) begin
                gnt1_cnt_q <= gnt1_cnt_q + 16'd1;
            end
            vld_q[0]  <= acc;
            tag_q[0]  <= acc1;
            data_q[0] <= acc0 ? bus.iv_req0_data : (acc1 ? bus.iv_req1_data : '0);
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inflight = inflight + 4'(vld_q[i]);
        end
    end

    always_comb begin
        bus.o_rsp0_valid = vld_q[DEPTH-1] & ~tag_q[DEPTH-1];
        bus.o_rsp1_valid = vld_q[DEPTH-1] & tag_q[DEPTH-1];
        bus.ov_rsp0_data = bus.o_rsp0_valid ? data_q[DEPTH-1] : '0;
        bus.ov_rsp1_data = bus.o_rsp1_valid ? data_q[DEPTH-1] : '0;
        bus.ov_inflight  = inflight;
        bus.ov_gnt0_cnt  = gnt0_cnt_q;
        bus.ov_gnt1_cnt  = gnt1_cnt_q;
    end
endmodule
